systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// Sequencer for a weight-streaming systolic array: clears the cells, reads K operand
// columns/rows, skews them into the array and pulses done. Optional SYSTOLIC_CTRL_PERF_CNT_EN adds run_cycles.
module systolic_ctrl #(
  parameter int ARRAY_WIDTH  = 2,
  parameter int ARRAY_HEIGHT = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int K_WIDTH      = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [K_WIDTH-1:0]                   k_len,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 rd_en,
  output logic [K_WIDTH-1:0]                   rd_k,
  input  logic [DATA_WIDTH*ARRAY_HEIGHT-1:0]   a_rd_data,
  input  logic [DATA_WIDTH*ARRAY_WIDTH-1:0]    b_rd_data,
  output logic                                 work,
  output logic [ARRAY_HEIGHT*ARRAY_WIDTH-1:0]  array_reset_n,
  output logic [DATA_WIDTH*ARRAY_HEIGHT-1:0]   a_array_input,
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  output logic [DATA_WIDTH*ARRAY_WIDTH-1:0]    b_array_input,
  output logic [31:0]                          run_cycles
`else
  output logic [DATA_WIDTH*ARRAY_WIDTH-1:0]    b_array_input
`endif
);

  localparam int CW = K_WIDTH + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // The last operand enters row H-1 / column W-1 and must still cross the array.
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(ARRAY_HEIGHT + ARRAY_WIDTH - 2);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [CW-1:0] kcnt_q, kcnt_d;
  logic [CW-1:0] drain_q, drain_d;
  logic          rd_vld_q;
  logic          abort_take;

  assign abort_take = abort && ((state_q == S_CLEAR) || (state_q == S_FEED) ||
                                (state_q == S_DRAIN));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    kcnt_d  = kcnt_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          k_d     = {2'b00, k_len};
        end
      end
      S_CLEAR: begin
        kcnt_d  = '0;
        state_d = (k_q == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        if ((kcnt_q + CW'(1)) == k_q) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          kcnt_d = kcnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_take) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      kcnt_q   <= '0;
      drain_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      kcnt_q   <= kcnt_d;
      drain_q  <= drain_d;
      rd_vld_q <= (state_q == S_FEED) && !abort_take;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign rd_en         = (state_q == S_FEED);
  assign rd_k          = rd_en ? kcnt_q[K_WIDTH-1:0] : '0;
  assign array_reset_n = (state_q == S_CLEAR) ? '0 : '1;
  // The first FEED cycle has no returned data yet, so work starts one cycle later.
  assign work          = ((state_q == S_FEED) && rd_vld_q) || (state_q == S_DRAIN);

  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_HEIGHT; gi++) begin : g_a_row
      if (gi == 0) begin : g_pass
        assign a_array_input[0 +: DATA_WIDTH] = rd_vld_q ? a_rd_data[0 +: DATA_WIDTH] : '0;
      end else begin : g_skew
        logic [DATA_WIDTH-1:0] dat_q [gi];
        logic [gi-1:0]         vld_q;
        always_ff @(posedge clk) begin
          if (reset || abort_take) begin
            for (int s = 0; s < gi; s++) begin
              dat_q[s] <= '0;
            end
            vld_q <= '0;
          end else begin
            dat_q[0] <= rd_vld_q ? a_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
            vld_q[0] <= rd_vld_q;
            for (int s = 1; s < gi; s++) begin
              dat_q[s] <= dat_q[s-1];
              vld_q[s] <= vld_q[s-1];
            end
          end
        end
        assign a_array_input[gi*DATA_WIDTH +: DATA_WIDTH] = vld_q[gi-1] ? dat_q[gi-1] : '0;
      end
    end

    for (gi = 0; gi < ARRAY_WIDTH; gi++) begin : g_b_col
      if (gi == 0) begin : g_pass
        assign b_array_input[0 +: DATA_WIDTH] = rd_vld_q ? b_rd_data[0 +: DATA_WIDTH] : '0;
      end else begin : g_skew
        logic [DATA_WIDTH-1:0] dat_q [gi];
        logic [gi-1:0]         vld_q;
        always_ff @(posedge clk) begin
          if (reset || abort_take) begin
            for (int s = 0; s < gi; s++) begin
              dat_q[s] <= '0;
            end
            vld_q <= '0;
          end else begin
            dat_q[0] <= rd_vld_q ? b_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
            vld_q[0] <= rd_vld_q;
            for (int s = 1; s < gi; s++) begin
              dat_q[s] <= dat_q[s-1];
              vld_q[s] <= vld_q[s-1];
            end
          end
        end
        assign b_array_input[gi*DATA_WIDTH +: DATA_WIDTH] = vld_q[gi-1] ? dat_q[gi-1] : '0;
      end
    end
  endgenerate

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  logic [31:0] run_cycles_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cycles_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      run_cycles_q <= '0;
    end else if (busy && (run_cycles_q != '1)) begin
      run_cycles_q <= run_cycles_q + 32'd1;
    end
  end

  assign run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl on a 2x2 array with a behavioural operand buffer
// and a 2x2 MAC array model fed from the skewed outputs.
module tb_systolic_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  k_len = 8'd0;
  logic        busy, done, rd_en, work;
  logic [7:0]  rd_k;
  logic [15:0] a_rd_data = 16'h0;
  logic [15:0] b_rd_data = 16'h0;
  logic [3:0]  array_reset_n;
  logic [15:0] a_array_input, b_array_input;
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  logic [31:0] run_cycles;
`endif

  systolic_ctrl #(
    .ARRAY_WIDTH (2),
    .ARRAY_HEIGHT(2),
    .DATA_WIDTH  (8),
    .K_WIDTH     (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .k_len        (k_len),
    .busy         (busy),
    .done         (done),
    .rd_en        (rd_en),
    .rd_k         (rd_k),
    .a_rd_data    (a_rd_data),
    .b_rd_data    (b_rd_data),
    .work         (work),
    .array_reset_n(array_reset_n),
    .a_array_input(a_array_input),
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    .b_array_input(b_array_input),
    .run_cycles   (run_cycles)
`else
    .b_array_input(b_array_input)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand buffers: A column k and B row k, one-cycle registered read.
  logic [7:0] amem [2][256];
  logic [7:0] bmem [2][256];
  always @(posedge clk) begin
    if (rd_en) begin
      a_rd_data <= {amem[1][rd_k], amem[0][rd_k]};
      b_rd_data <= {bmem[1][rd_k], bmem[0][rd_k]};
    end
  end

  // 2x2 output-stationary MAC array: A moves right, B moves down.
  logic [7:0] ar [2][2];
  logic [7:0] br [2][2];
  logic [7:0] na [2][2];
  logic [7:0] nb [2][2];
  int         acc [2][2];
  int work_cnt, rd_cnt, done_cnt, clear_cnt, rdk_err;
  int first_work, last_work, first_rd;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (j == 0) na[i][j] = a_array_input[i*8 +: 8];
        else        na[i][j] = ar[i][j-1];
        if (i == 0) nb[i][j] = b_array_input[j*8 +: 8];
        else        nb[i][j] = br[i-1][j];
      end
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (array_reset_n[i*2+j] === 1'b0) begin
          acc[i][j] = 0;
          ar[i][j]  = 8'd0;
          br[i][j]  = 8'd0;
        end else if (work === 1'b1) begin
          acc[i][j] = acc[i][j] + int'(na[i][j]) * int'(nb[i][j]);
          ar[i][j]  = na[i][j];
          br[i][j]  = nb[i][j];
        end
      end
    end
    if (work === 1'b1) begin
      work_cnt++;
      if (first_work < 0) first_work = cyc;
      last_work = cyc;
    end
    if (rd_en === 1'b1) begin
      if (rd_k !== rd_cnt[7:0]) rdk_err++;
      if (first_rd < 0) first_rd = cyc;
      rd_cnt++;
    end
    if (done === 1'b1) done_cnt++;
    if (array_reset_n === 4'h0) clear_cnt++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    work_cnt = 0; rd_cnt = 0; done_cnt = 0; clear_cnt = 0; rdk_err = 0;
    first_work = -1; last_work = -1; first_rd = -1;
  endtask

  task automatic wait_done(input string tag, input int t);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
    $display("run %s: done at T+%0d", tag, cyc - t);
  endtask

  task automatic check_c(input string tag);
    check({tag, "_c00"}, acc[0][0], 4);
    check({tag, "_c01"}, acc[0][1], 5);
    check({tag, "_c10"}, acc[1][0], 10);
    check({tag, "_c11"}, acc[1][1], 11);
  endtask

  // Plain K=3 run from IDLE: timing and C checked.
  task automatic std_run(input string tag);
    int t;
    clr_stats();
    t = cyc; start = 1'b1; k_len = 8'd3;
    tick();
    start = 1'b0;
    wait_done(tag, t);
    check({tag, "_done_at"}, cyc - t, 8);
    check({tag, "_work_cnt"}, work_cnt, 5);
    check_c(tag);
    tick();
  endtask

  initial begin
    int t;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 256; k++) begin
        amem[i][k] = 8'd0;
        bmem[i][k] = 8'd0;
      end
      for (int j = 0; j < 2; j++) begin
        ar[i][j] = 8'd0; br[i][j] = 8'd0; acc[i][j] = 0;
      end
    end
    // A = [[1,2,3],[4,5,6]], B = [[1,0],[0,1],[1,1]]
    amem[0][0] = 8'd1; amem[0][1] = 8'd2; amem[0][2] = 8'd3;
    amem[1][0] = 8'd4; amem[1][1] = 8'd5; amem[1][2] = 8'd6;
    bmem[0][0] = 8'd1; bmem[1][0] = 8'd0;
    bmem[0][1] = 8'd0; bmem[1][1] = 8'd1;
    bmem[0][2] = 8'd1; bmem[1][2] = 8'd1;
    clr_stats();

    // Reset state
    tick(); tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_k", rd_k, 0);
    check("rst_work", work, 0);
    check("rst_arn", array_reset_n, 4'hF);
    check("rst_a_in", a_array_input, 0);
    check("rst_b_in", b_array_input, 0);
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    check("rst_run_cycles", run_cycles, 0);
`endif
    reset = 1'b0;
    tick();

    // Basic K=3 run with skew spot checks
    clr_stats();
    t = cyc; start = 1'b1; k_len = 8'd3;
    tick();
    start = 1'b0;
    check("a_clear_t1", array_reset_n, 4'h0);
    check("a_busy_t1", busy, 1);
    tick(); tick();
    check("a_a_in_t3", a_array_input, 16'h0001);
    check("a_b_in_t3", b_array_input, 16'h0001);
    tick();
    check("a_a_in_t4", a_array_input, 16'h0402);
    check("a_b_in_t4", b_array_input, 16'h0000);
    wait_done("a", t);
    check("a_done_at", cyc - t, 8);
    check("a_first_rd", first_rd - t, 2);
    check("a_rd_cnt", rd_cnt, 3);
    check("a_rdk_err", rdk_err, 0);
    check("a_first_work", first_work - t, 3);
    check("a_last_work", last_work - t, 7);
    check("a_work_cnt", work_cnt, 5);
    check("a_clear_cnt", clear_cnt, 1);
    check_c("a");
    tick();
    check("a_idle_busy", busy, 0);
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    check("a_run_cycles", run_cycles, 8);
    tick(); tick(); tick();
    check("a_run_cycles_hold", run_cycles, 8);
`endif

    // K=0: CLEAR straight to DONE
    clr_stats();
    t = cyc; start = 1'b1; k_len = 8'd0;
    tick();
    start = 1'b0;
    check("k0_clear_t1", array_reset_n, 4'h0);
    wait_done("k0", t);
    check("k0_done_at", cyc - t, 2);
    check("k0_rd_cnt", rd_cnt, 0);
    check("k0_work_cnt", work_cnt, 0);
    tick();
    check("k0_idle_busy", busy, 0);

    // start held high: second run accepted only after DONE
    clr_stats();
    t = cyc; start = 1'b1; k_len = 8'd3;
    tick();
    wait_done("held1", t);
    check("held1_done_at", cyc - t, 8);
    check("held1_clear_cnt", clear_cnt, 1);
    tick();
    check("held_idle_busy", busy, 0);
    tick();
    check("held2_busy", busy, 1);
    check("held2_clear", array_reset_n, 4'h0);
    start = 1'b0;
    wait_done("held2", t);
    check("held2_done_at", cyc - t, 17);
    check("held2_clear_cnt", clear_cnt, 2);
    check_c("held2");
    tick();

    // abort in FEED at T+3
    clr_stats();
    t = cyc; start = 1'b1; k_len = 8'd3;
    tick();
    start = 1'b0;
    tick(); tick();
    check("ab_work_t3", work, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy_t4", busy, 0);
    check("ab_work_t4", work, 0);
    check("ab_rd_en_t4", rd_en, 0);
    check("ab_a_in_t4", a_array_input, 0);
    check("ab_b_in_t4", b_array_input, 0);
    for (int i = 0; i < 15; i++) tick();
    check("ab_no_done", done_cnt, 0);
    check("ab_work_cnt", work_cnt, 1);
    std_run("ab_rerun");

    // reset asserted in DRAIN (T+6)
    clr_stats();
    t = cyc; start = 1'b1; k_len = 8'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("rd_drain_work", work, 1);
    reset = 1'b1;
    tick();
    check("rd_busy", busy, 0);
    check("rd_done", done, 0);
    check("rd_rd_en", rd_en, 0);
    check("rd_rd_k", rd_k, 0);
    check("rd_work", work, 0);
    check("rd_arn", array_reset_n, 4'hF);
    check("rd_a_in", a_array_input, 0);
    check("rd_b_in", b_array_input, 0);
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    check("rd_run_cycles", run_cycles, 0);
`endif
    reset = 1'b0;
    tick();
    check("rd_no_done", done_cnt, 0);
    std_run("rd_rerun");

    // start and abort together in IDLE: start wins
    clr_stats();
    t = cyc; start = 1'b1; abort = 1'b1; k_len = 8'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, 1);
    wait_done("sa", t);
    check("sa_done_at", cyc - t, 8);
    check_c("sa");
    tick();

    // Maximum K: counters must not wrap
    clr_stats();
    t = cyc; start = 1'b1; k_len = 8'd255;
    tick();
    start = 1'b0;
    wait_done("kmax", t);
    check("kmax_done_at", cyc - t, 260);
    check("kmax_rd_cnt", rd_cnt, 255);
    check("kmax_rdk_err", rdk_err, 0);
    check("kmax_work_cnt", work_cnt, 257);
    check("kmax_last_work", last_work - t, 259);
    check_c("kmax");
    tick();
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    check("kmax_run_cycles", run_cycles, 260);
`endif
    check("kmax_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
